// File: rtl/game_pkg.sv
// Shared types and command encoding for the game-state history block.
package game_pkg;

  localparam int GAME_STATE_W = 134;

  typedef logic [GAME_STATE_W-1:0] game_state_t;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_LOAD  = 3'd2,
    CMD_UNDO  = 3'd3,
    CMD_REDO  = 3'd4
  } cmd_e;

  // Only the highest-priority command in a cycle is acted on.
  function automatic cmd_e pick_cmd(input logic clear, input logic load,
                                    input logic undo, input logic redo);
    cmd_e c;
    c = CMD_NONE;
    if (clear)     c = CMD_CLEAR;
    else if (load) c = CMD_LOAD;
    else if (undo) c = CMD_UNDO;
    else if (redo) c = CMD_REDO;
    return c;
  endfunction

endpackage

// File: rtl/game_hist_ring.sv
// DEPTH-entry undo ring: push at the write pointer, pop from the entry below it.
// When full, a push overwrites the oldest entry and the count stays at DEPTH.
module game_hist_ring
  import game_pkg::*;
#(
  parameter int N     = GAME_STATE_W,
  parameter int DEPTH = 8,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [N-1:0]    push_data,
  output logic [N-1:0]    top_data,
  output logic [CNTW-1:0] count
);

  logic [N-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   top_ptr;
  logic [CNTW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != CNTW'(DEPTH)) count_d = count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      wr_ptr_d = wr_ptr_q - 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible through count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && !flush && (wr_ptr_q == PW'(gi))) mem_q[gi] <= push_data;
    end
  end

  assign top_ptr  = wr_ptr_q - 1'b1;
  assign top_data = mem_q[top_ptr];
  assign count    = count_q;

endmodule

// File: rtl/game_state_hist.sv
// Source-select + current game-state register with DEPTH-entry undo history.
// Optional single-level redo enabled by defining GAME_HIST_REDO_EN.
module game_state_hist
  import game_pkg::*;
#(
  parameter int N     = GAME_STATE_W,
  parameter int SRC   = 4,
  parameter int DEPTH = 8,
  localparam int SELW = (SRC > 1) ? $clog2(SRC) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  sel,
  input  logic [SRC*N-1:0] in_flat,
  input  logic             load,
  input  logic             undo,
  input  logic             clear,
  output logic [N-1:0]     cur_state,
  output logic             cur_valid,
  output logic [CNTW-1:0]  hist_count,
  output logic             hist_empty,
  output logic             hist_full,
  output logic             undo_err
`ifdef GAME_HIST_REDO_EN
  ,
  input  logic             redo,
  output logic             redo_valid
`endif
);

  logic [N-1:0] src_arr [SRC];
  logic [N-1:0] src_sel;
  logic [N-1:0] cur_state_q, cur_state_d;
  logic         cur_valid_q, cur_valid_d;
  logic         undo_err_q, undo_err_d;
  logic         ring_push, ring_pop, ring_flush;
  logic [N-1:0] ring_top;
  logic         redo_req;
  cmd_e         cmd;

`ifdef GAME_HIST_REDO_EN
  logic [N-1:0] redo_state_q, redo_state_d;
  logic         redo_valid_q, redo_valid_d;
  assign redo_req = redo;
`else
  assign redo_req = 1'b0;
`endif

  for (genvar gi = 0; gi < SRC; gi++) begin : g_src
    assign src_arr[gi] = in_flat[gi*N +: N];
  end

  // Out-of-range select (non-power-of-two SRC) falls back to source 0.
  always_comb begin
    src_sel = src_arr[0];
    for (int k = 1; k < SRC; k++) begin
      if (32'(sel) == k) src_sel = src_arr[k];
    end
  end

  assign cmd = pick_cmd(clear, load, undo, redo_req);

  always_comb begin
    cur_state_d = cur_state_q;
    cur_valid_d = cur_valid_q;
    undo_err_d  = 1'b0;
    ring_push   = 1'b0;
    ring_pop    = 1'b0;
    ring_flush  = 1'b0;
`ifdef GAME_HIST_REDO_EN
    redo_state_d = redo_state_q;
    redo_valid_d = redo_valid_q;
`endif
    unique case (cmd)
      CMD_CLEAR: begin
        ring_flush = 1'b1;
`ifdef GAME_HIST_REDO_EN
        redo_valid_d = 1'b0;
`endif
      end
      CMD_LOAD: begin
        ring_push   = cur_valid_q;
        cur_state_d = src_sel;
        cur_valid_d = 1'b1;
`ifdef GAME_HIST_REDO_EN
        redo_valid_d = 1'b0;
`endif
      end
      CMD_UNDO: begin
        if (!hist_empty && cur_valid_q) begin
          ring_pop    = 1'b1;
          cur_state_d = ring_top;
`ifdef GAME_HIST_REDO_EN
          redo_state_d = cur_state_q;
          redo_valid_d = 1'b1;
`endif
        end else begin
          undo_err_d = 1'b1;
        end
      end
`ifdef GAME_HIST_REDO_EN
      CMD_REDO: begin
        if (redo_valid_q) begin
          ring_push    = cur_valid_q;
          cur_state_d  = redo_state_q;
          cur_valid_d  = 1'b1;
          redo_valid_d = 1'b0;
        end else begin
          undo_err_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state_q <= '0;
      cur_valid_q <= 1'b0;
      undo_err_q  <= 1'b0;
    end else begin
      cur_state_q <= cur_state_d;
      cur_valid_q <= cur_valid_d;
      undo_err_q  <= undo_err_d;
    end
  end

`ifdef GAME_HIST_REDO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      redo_valid_q <= 1'b0;
    end else begin
      redo_valid_q <= redo_valid_d;
    end
    redo_state_q <= redo_state_d;
  end
  assign redo_valid = redo_valid_q;
`endif

  game_hist_ring #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .flush     (ring_flush),
    .push      (ring_push),
    .pop       (ring_pop),
    .push_data (cur_state_q),
    .top_data  (ring_top),
    .count     (hist_count)
  );

  assign cur_state  = cur_state_q;
  assign cur_valid  = cur_valid_q;
  assign hist_empty = (hist_count == '0);
  assign hist_full  = (hist_count == CNTW'(DEPTH));
  assign undo_err   = undo_err_q;

endmodule

// File: tb/tb_game_state_hist.sv
// Scoreboard bench: a queue-based history model predicts every cycle's outputs.
module tb_game_state_hist;
  import game_pkg::*;

  localparam int N     = GAME_STATE_W;
  localparam int SRC   = 4;
  localparam int DEPTH = 8;
  localparam int SELW  = $clog2(SRC);
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SELW-1:0]  sel = '0;
  logic [SRC*N-1:0] in_flat;
  logic             load = 1'b0, undo = 1'b0, clear = 1'b0;
  logic [N-1:0]     cur_state;
  logic             cur_valid, hist_empty, hist_full, undo_err;
  logic [CNTW-1:0]  hist_count;
  logic             redo = 1'b0;
  logic             redo_valid;
  logic [N-1:0]     src [SRC];

  // Second instance with non-power-of-two SRC for the out-of-range select case.
  logic             rst3 = 1'b1, load3 = 1'b0;
  logic [1:0]       sel3 = '0;
  logic [3*N-1:0]   in3;
  logic [N-1:0]     cur3;
  logic             valid3, empty3, full3, err3, redo_valid3;
  logic [CNTW-1:0]  count3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_flat = '0;
    for (int k = 0; k < SRC; k++) in_flat[k*N +: N] = src[k];
  end

  game_state_hist #(.N(N), .SRC(SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in_flat(in_flat),
    .load(load), .undo(undo), .clear(clear),
    .cur_state(cur_state), .cur_valid(cur_valid), .hist_count(hist_count),
    .hist_empty(hist_empty), .hist_full(hist_full), .undo_err(undo_err)
`ifdef GAME_HIST_REDO_EN
    , .redo(redo), .redo_valid(redo_valid)
`endif
  );

  game_state_hist #(.N(N), .SRC(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst3), .sel(sel3), .in_flat(in3),
    .load(load3), .undo(1'b0), .clear(1'b0),
    .cur_state(cur3), .cur_valid(valid3), .hist_count(count3),
    .hist_empty(empty3), .hist_full(full3), .undo_err(err3)
`ifdef GAME_HIST_REDO_EN
    , .redo(1'b0), .redo_valid(redo_valid3)
`endif
  );

  typedef struct {
    logic [N-1:0] cur;
    logic         valid;
    int           cnt;
    logic         err;
    logic         rv;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_cur = '0;
  logic [N-1:0] m_redo = '0;
  logic         m_valid = 1'b0;
  logic         m_rv = 1'b0;

  function automatic logic [N-1:0] rnd_state();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[N-1:0];
  endfunction

  task automatic m_push(input logic [N-1:0] v);
    m_hist.push_back(v);
    if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
  endtask

  // Drive one cycle of commands and push the model's prediction.
  task automatic cycle(input bit l, input bit u, input bit c, input bit r,
                       input bit rd, input logic [SELW-1:0] s);
    exp_t e;
    logic err;
    rst = r; clear = c; load = l; undo = u; sel = s;
`ifdef GAME_HIST_REDO_EN
    redo = rd;
`endif
    err = 1'b0;
    if (r) begin
      m_cur = '0; m_valid = 1'b0; m_rv = 1'b0; m_hist.delete();
    end else if (c) begin
      m_hist.delete(); m_rv = 1'b0;
    end else if (l) begin
      if (m_valid) m_push(m_cur);
      m_cur = src[s]; m_valid = 1'b1; m_rv = 1'b0;
    end else if (u) begin
      if (m_hist.size() > 0 && m_valid) begin
        m_redo = m_cur; m_rv = 1'b1; m_cur = m_hist.pop_back();
      end else err = 1'b1;
`ifdef GAME_HIST_REDO_EN
    end else if (rd) begin
      if (m_rv) begin
        if (m_valid) m_push(m_cur);
        m_cur = m_redo; m_rv = 1'b0; m_valid = 1'b1;
      end else err = 1'b1;
`endif
    end
    e.cur = m_cur; e.valid = m_valid; e.cnt = m_hist.size(); e.err = err; e.rv = m_rv;
    sb_q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0; clear = 1'b0; load = 1'b0; undo = 1'b0; redo = 1'b0;
  endtask

  // Scoreboard monitor: compares each prediction one edge after it was driven.
  always begin
    int due;
    exp_t e;
    @(posedge clk);
    due = sb_q.size();
    #2;
    for (int i = 0; i < due; i++) begin
      e = sb_q.pop_front();
      n_checks++;
      if (cur_state !== e.cur) begin
        n_fail++; $display("FAIL sb_cur_state got %h want %h", cur_state, e.cur);
      end
      n_checks++;
      if (cur_valid !== e.valid) begin
        n_fail++; $display("FAIL sb_cur_valid got %b want %b", cur_valid, e.valid);
      end
      n_checks++;
      if (hist_count !== CNTW'(e.cnt)) begin
        n_fail++; $display("FAIL sb_hist_count got %0d want %0d", hist_count, e.cnt);
      end
      n_checks++;
      if (hist_empty !== (e.cnt == 0) || hist_full !== (e.cnt == DEPTH)) begin
        n_fail++; $display("FAIL sb_empty_full got %b/%b want count %0d", hist_empty, hist_full, e.cnt);
      end
      n_checks++;
      if (undo_err !== e.err) begin
        n_fail++; $display("FAIL sb_undo_err got %b want %b", undo_err, e.err);
      end
`ifdef GAME_HIST_REDO_EN
      n_checks++;
      if (redo_valid !== e.rv) begin
        n_fail++; $display("FAIL sb_redo_valid got %b want %b", redo_valid, e.rv);
      end
`endif
      $display("txn cur=%h valid=%b cnt=%0d err=%b", cur_state, cur_valid, hist_count, undo_err);
    end
  end

  task automatic test_reset();
    cycle(0, 0, 0, 1, 0, '0);
    cycle(0, 0, 0, 1, 0, '0);
    n_checks++;
    if (cur_state !== '0 || cur_valid !== 1'b0 || hist_count !== '0 || undo_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got cur=%h v=%b cnt=%0d err=%b want all zero",
                          cur_state, cur_valid, hist_count, undo_err);
    end
  endtask

  task automatic test_load_basic();
    logic [N-1:0] a5;
    a5 = '0; a5[7:0] = 8'hA5;
    src[2] = a5;
    cycle(1, 0, 0, 0, 0, 2'd2);
    n_checks++;
    if (cur_state !== a5 || cur_valid !== 1'b1 || hist_count !== '0) begin
      n_fail++; $display("FAIL load_sel2 got cur=%h v=%b cnt=%0d want %h 1 0",
                          cur_state, cur_valid, hist_count, a5);
    end
  endtask

  task automatic test_undo_seq();
    logic [N-1:0] s [4];
    cycle(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) begin
      s[i] = rnd_state(); src[1] = s[i];
      cycle(1, 0, 0, 0, 0, 2'd1);
    end
    for (int i = 2; i >= 0; i--) begin
      cycle(0, 1, 0, 0, 0, '0);
      n_checks++;
      if (cur_state !== s[i] || hist_count !== CNTW'(i)) begin
        n_fail++; $display("FAIL undo_step%0d got cur=%h cnt=%0d want %h %0d",
                            i, cur_state, hist_count, s[i], i);
      end
    end
    cycle(0, 1, 0, 0, 0, '0);
    n_checks++;
    if (undo_err !== 1'b1 || cur_state !== s[0]) begin
      n_fail++; $display("FAIL undo_empty got err=%b cur=%h want 1 %h", undo_err, cur_state, s[0]);
    end
    cycle(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_full_wrap();
    logic [N-1:0] s [11];
    cycle(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 11; i++) begin
      s[i] = rnd_state(); src[0] = s[i];
      cycle(1, 0, 0, 0, 0, 2'd0);
    end
    n_checks++;
    if (hist_full !== 1'b1 || hist_count !== CNTW'(DEPTH)) begin
      n_fail++; $display("FAIL full_after_11 got full=%b cnt=%0d want 1 %0d", hist_full, hist_count, DEPTH);
    end
    for (int i = 9; i >= 2; i--) begin
      cycle(0, 1, 0, 0, 0, '0);
      n_checks++;
      if (cur_state !== s[i]) begin
        n_fail++; $display("FAIL wrap_undo%0d got %h want %h", i, cur_state, s[i]);
      end
    end
    cycle(0, 1, 0, 0, 0, '0);
    n_checks++;
    if (undo_err !== 1'b1) begin
      n_fail++; $display("FAIL wrap_undo9_err got %b want 1", undo_err);
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] held;
    cycle(0, 0, 0, 1, 0, '0);
    src[3] = rnd_state(); cycle(1, 0, 0, 0, 0, 2'd3);
    src[3] = rnd_state(); cycle(1, 1, 0, 0, 0, 2'd3);
    n_checks++;
    if (hist_count !== CNTW'(1) || undo_err !== 1'b0 || cur_state !== src[3]) begin
      n_fail++; $display("FAIL load_beats_undo got cnt=%0d err=%b want 1 0", hist_count, undo_err);
    end
    held = cur_state;
    src[3] = rnd_state(); cycle(1, 0, 1, 0, 0, 2'd3);
    n_checks++;
    if (hist_count !== '0 || cur_state !== held) begin
      n_fail++; $display("FAIL clear_beats_load got cnt=%0d cur=%h want 0 %h", hist_count, cur_state, held);
    end
    cycle(0, 1, 1, 0, 0, '0);
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 6; i++) begin
      src[i % SRC] = rnd_state(); cycle(1, 0, 0, 0, 0, SELW'(i % SRC));
    end
    cycle(0, 0, 0, 1, 0, '0);
    n_checks++;
    if (hist_count !== '0 || cur_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got cnt=%0d v=%b want 0 0", hist_count, cur_valid);
    end
  endtask

  task automatic test_sel_oob();
    logic [N-1:0] s3 [3];
    for (int k = 0; k < 3; k++) begin
      s3[k] = rnd_state(); in3[k*N +: N] = s3[k];
    end
    rst3 = 1'b1; @(posedge clk); #1; rst3 = 1'b0;
    sel3 = 2'd3; load3 = 1'b1; @(posedge clk); #1; load3 = 1'b0;
    n_checks++;
    if (cur3 !== s3[0] || valid3 !== 1'b1) begin
      n_fail++; $display("FAIL sel_oob got %h want %h", cur3, s3[0]);
    end
    sel3 = 2'd2; load3 = 1'b1; @(posedge clk); #1; load3 = 1'b0;
    n_checks++;
    if (cur3 !== s3[2] || count3 !== CNTW'(1)) begin
      n_fail++; $display("FAIL sel3_src2 got %h cnt=%0d want %h 1", cur3, count3, s3[2]);
    end
  endtask

`ifdef GAME_HIST_REDO_EN
  task automatic test_redo();
    logic [N-1:0] s1, s2;
    cycle(0, 0, 0, 1, 0, '0);
    s1 = rnd_state(); src[0] = s1; cycle(1, 0, 0, 0, 0, 2'd0);
    s2 = rnd_state(); src[0] = s2; cycle(1, 0, 0, 0, 0, 2'd0);
    cycle(0, 1, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 1, '0);
    n_checks++;
    if (cur_state !== s2 || hist_count !== CNTW'(1) || redo_valid !== 1'b0) begin
      n_fail++; $display("FAIL redo_restore got cur=%h cnt=%0d rv=%b want %h 1 0",
                          cur_state, hist_count, redo_valid, s2);
    end
    cycle(0, 1, 0, 0, 0, '0);
    src[1] = rnd_state(); cycle(1, 0, 0, 0, 0, 2'd1);
    cycle(0, 0, 0, 0, 1, '0);
    n_checks++;
    if (undo_err !== 1'b1) begin
      n_fail++; $display("FAIL redo_after_load_err got %b want 1", undo_err);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int r;
    cycle(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) src[$urandom_range(0, SRC-1)] = rnd_state();
      r = $urandom_range(0, 99);
      cycle(r < 45, (r >= 30 && r < 80), (r >= 95 && r < 98), r >= 98,
            (r >= 70 && r < 95), SELW'($urandom_range(0, SRC-1)));
    end
  endtask

  initial begin
    for (int k = 0; k < SRC; k++) src[k] = '0;
    in3 = '0;
    test_reset();
    test_load_basic();
    test_undo_seq();
    test_full_wrap();
    test_priority();
    test_reset_mid();
    test_sel_oob();
`ifdef GAME_HIST_REDO_EN
    test_redo();
`endif
    test_back_to_back();
    #20;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_hist.md
Name: game_state_hist

Overview:
- Successor to the fixed 4:1 game-state selector. It selects one of SRC game-state sources, registers the result as the current game state, and keeps a DEPTH-entry undo history.
- It sits between the move/level-load logic (the sources) and the renderer/win-checker (the current-state consumers).
- It replaces the combinational mux plus external state register.

Parameters:
- N, 134, game-state width in bits (board encoding plus player position).
- SRC, 4, number of selectable state sources (≥2).
- DEPTH, 8, undo history entries (≥2, power of two).
- SELW, $clog2(SRC), select width (derived, not overridden).
- CNTW, $clog2(DEPTH+1), history count width (derived).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  SELW  source index for load.
- in_flat  in  SRC*N  concatenated sources; source k is in_flat[k*N +: N].
- load  in  1  capture source[sel] as new current state; push old current onto history.
- undo  in  1  pop newest history entry into current state.
- clear  in  1  flush history and keep current state (level restart).
- cur_state  out  N  registered current game state.
- cur_valid  out  1  cur_state holds a loaded state.
- hist_count  out  CNTW  valid history entries, 0..DEPTH.
- hist_empty  out  1  hist_count==0.
- hist_full  out  1  hist_count==DEPTH.
- undo_err  out  1  one-cycle pulse: undo requested with empty history or !cur_valid.

Behaviour:
- Reset (synchronous, active-high): cur_state=0, cur_valid=0, hist_count=0, write pointer=0, undo_err=0. History RAM contents are don't-care. rst mid-operation discards all history in the same edge.
- Command priority per cycle: rst > clear > load > undo. Lower-priority commands in the same cycle are ignored and produce no undo_err.
- load, cycle-level behaviour:
  - At the edge: cur_state <= source[sel], cur_valid <= 1.
  - If cur_valid was 1, old cur_state is written at the write pointer, the pointer increments mod DEPTH, and hist_count increments saturating at DEPTH.
  - When full, the oldest entry is silently overwritten (ring wrap); hist_full stays 1.
  - First load after reset or clear with cur_valid=0 pushes nothing.
  - Latency is 1 cycle: new state is visible on cur_state the cycle after load.
- sel ≥ SRC (non-power-of-two SRC): source 0 is selected.
- undo:
  - If hist_count>0 and cur_valid: cur_state <= entry at (pointer-1) mod DEPTH; pointer decrements mod DEPTH; hist_count decrements.
  - Otherwise state is unchanged and undo_err pulses high for exactly the next cycle.
  - Latency is 1 cycle.
- clear: hist_count <= 0, pointer <= 0; cur_state and cur_valid are unchanged.
- hist_empty and hist_full are combinational decodes of registered hist_count.
- No handshake backpressure: every command completes in one cycle. Held-high inputs act once per cycle (level-sensitive); upstream edge-detects buttons.

Optional Feature:
- Macro: GAME_HIST_REDO_EN.
- With the macro, add input redo (1) and output redo_valid (1), plus a single-level redo register:
  - A successful undo copies the pre-undo cur_state into the redo register and sets redo_valid=1.
  - redo with redo_valid=1 pushes cur_state (same rules as load), sets cur_state <= redo register, and clears redo_valid.
  - redo with redo_valid=0 pulses undo_err.
  - load, clear and rst clear redo_valid.
  - Priority is clear > load > undo > redo.
- Without the macro, the port and the register are absent and behaviour is as above.

Decomposition:
- Shared package game_pkg: GAME_STATE_W=134 constant, game_state_t typedef, command priority encoding constants.
- One sub-module, game_hist_ring: DEPTH×N register array with write pointer, count and push/pop logic, exposing the top entry combinationally.
- The top level holds the source select, current-state register, command arbitration and redo option.

Test Plan:
- Reset, then load sel=2 with source2=0x...A5 → cur_state=0x...A5 next cycle, cur_valid=1, hist_count=0.
- Load states S1..S4 in sequence, then 3 undos → cur_state=S3,S2,S1 on successive cycles; hist_count 3→0; a 4th undo → undo_err pulse, cur_state=S1.
- DEPTH=8: load S0..S10 (11 loads, 10 pushes) → hist_full=1, count=8; 8 undos return S9 down to S2; 9th undo flags undo_err.
- Same-cycle load+undo → load wins, count +1, no undo_err. Same-cycle clear+load → only clear, count=0, cur_state unchanged.
- sel=3 with SRC=3 → source 0 loaded. rst asserted mid-sequence with count=5 → count=0, cur_valid=0 next cycle.
- With GAME_HIST_REDO_EN: load S1,S2, undo (cur=S1), redo → cur=S2, count=1, redo_valid=0. undo then load S3 → redo_valid=0; subsequent redo → undo_err.
